// File: rtl/axi4_lite_mem_slave_pkg.sv
// Shared response codes and FSM encodings for the AXI4-Lite line-memory responder.
package axi4_lite_mem_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_COMMIT = 2'd1,
        W_RESP   = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ACC  = 2'd1,
        R_DATA = 2'd2
    } r_state_t;

endpackage

// File: rtl/axi4_lite_line_ram.sv
// Single-port line RAM split into per-lane banks; read register only updates on re.
module axi4_lite_line_ram #(
    parameter int DATA_W = 128,
    parameter int STRB_W = 8,
    parameter int DEPTH  = 128,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     idx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    output logic [DATA_W-1:0] rdata
);

    localparam int LANE_W = DATA_W / STRB_W;

    for (genvar g = 0; g < STRB_W; g++) begin : g_lane
        logic [LANE_W-1:0] bank [DEPTH];
        logic [LANE_W-1:0] rd_q;

        always_ff @(posedge clk) begin
            if (we && wstrb[g])
                bank[idx] <= wdata[g*LANE_W +: LANE_W];
            if (re)
                rd_q <= bank[idx];
        end

        assign rdata[g*LANE_W +: LANE_W] = rd_q;
    end

endmodule

// File: rtl/axi4_lite_mem_slave.sv
// AXI4-Lite responder backed by one line RAM; writes win the shared port over reads.
module axi4_lite_mem_slave
    import axi4_lite_mem_slave_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 128,
    parameter int STRB_W = 8,
    parameter int DEPTH  = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] S_AXI_AWADDR,
    input  logic              S_AXI_AWVALID,
    output logic              S_AXI_AWREADY,
    input  logic [DATA_W-1:0] S_AXI_WDATA,
    input  logic [STRB_W-1:0] S_AXI_WSTRB,
    input  logic              S_AXI_WVALID,
    output logic              S_AXI_WREADY,
    output logic [1:0]        S_AXI_BRESP,
    output logic              S_AXI_BVALID,
    input  logic              S_AXI_BREADY,
    input  logic [ADDR_W-1:0] S_AXI_ARADDR,
    input  logic              S_AXI_ARVALID,
    output logic              S_AXI_ARREADY,
    output logic [DATA_W-1:0] S_AXI_RDATA,
    output logic [1:0]        S_AXI_RRESP,
    output logic              S_AXI_RVALID,
    input  logic              S_AXI_RREADY
);

    localparam int OFF_W  = $clog2(DATA_W / 8);
    localparam int IDX_W  = ADDR_W - OFF_W;
    localparam int RAM_AW = $clog2(DEPTH);
    localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic              aw_held, w_held, aw_held_d, w_held_d;
    logic              aw_ready_q, w_ready_q, ar_ready_q;
    logic              aw_hs, w_hs, ar_hs;
    logic [IDX_W-1:0]  aw_idx_q, ar_idx_q;
    logic [DATA_W-1:0] wdata_q, ram_rdata;
    logic [STRB_W-1:0] wstrb_q;
    logic              w_in_range, r_in_range;
    logic              ram_we, ram_re;
    logic [RAM_AW-1:0] ram_idx;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{S_AXI_AWADDR[OFF_W-1:0], S_AXI_ARADDR[OFF_W-1:0]};

    assign aw_hs = aw_ready_q && S_AXI_AWVALID;
    assign w_hs  = w_ready_q  && S_AXI_WVALID;
    assign ar_hs = ar_ready_q && S_AXI_ARVALID;

    assign w_in_range = {1'b0, aw_idx_q} < DEPTH_L;
    assign r_in_range = {1'b0, ar_idx_q} < DEPTH_L;

    always_comb begin
        w_next    = w_state;
        aw_held_d = aw_held;
        w_held_d  = w_held;
        unique case (w_state)
            W_IDLE: begin
                aw_held_d = aw_held || aw_hs;
                w_held_d  = w_held  || w_hs;
                if (aw_held_d && w_held_d)
                    w_next = W_COMMIT;
            end
            W_COMMIT: w_next = W_RESP;
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    w_next    = W_IDLE;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    // READYs are registered so they depend only on state and drop while in reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            w_state    <= W_IDLE;
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
        end else begin
            w_state    <= w_next;
            aw_held    <= aw_held_d;
            w_held     <= w_held_d;
            aw_ready_q <= (w_next == W_IDLE) && !aw_held_d;
            w_ready_q  <= (w_next == W_IDLE) && !w_held_d;
            if (aw_hs)
                aw_idx_q <= S_AXI_AWADDR[ADDR_W-1:OFF_W];
            if (w_hs) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
        end
    end

    always_comb begin
        r_next = r_state;
        ram_re = 1'b0;
        unique case (r_state)
            R_IDLE: if (ar_hs) r_next = R_ACC;
            R_ACC: begin
                // Hold off while a commit owns the RAM so the read sees post-write data.
                if (w_state != W_COMMIT) begin
                    ram_re = r_in_range;
                    r_next = R_DATA;
                end
            end
            R_DATA: if (S_AXI_RREADY) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= R_IDLE;
            ar_ready_q <= 1'b0;
        end else begin
            r_state    <= r_next;
            ar_ready_q <= (r_next == R_IDLE);
            if (ar_hs)
                ar_idx_q <= S_AXI_ARADDR[ADDR_W-1:OFF_W];
        end
    end

    assign ram_we  = (w_state == W_COMMIT) && w_in_range && rst;
    assign ram_idx = ram_we ? aw_idx_q[RAM_AW-1:0] : ar_idx_q[RAM_AW-1:0];

    axi4_lite_line_ram #(
        .DATA_W (DATA_W),
        .STRB_W (STRB_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .idx   (ram_idx),
        .wdata (wdata_q),
        .wstrb (wstrb_q),
        .rdata (ram_rdata)
    );

    assign S_AXI_AWREADY = aw_ready_q;
    assign S_AXI_WREADY  = w_ready_q;
    assign S_AXI_ARREADY = ar_ready_q;
    assign S_AXI_BVALID  = (w_state == W_RESP);
    assign S_AXI_BRESP   = (S_AXI_BVALID && !w_in_range) ? RESP_DECERR : RESP_OKAY;
    assign S_AXI_RVALID  = (r_state == R_DATA);
    assign S_AXI_RRESP   = (S_AXI_RVALID && !r_in_range) ? RESP_DECERR : RESP_OKAY;
    assign S_AXI_RDATA   = (S_AXI_RVALID && r_in_range) ? ram_rdata : '0;

endmodule

// File: tb/tb_axi4_lite_mem_slave.sv
// Directed plus randomized bench for axi4_lite_mem_slave against a line-level memory model.
module tb_axi4_lite_mem_slave;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 128;
    localparam int STRB_W = 8;
    localparam int DEPTH  = 128;
    localparam int LANE_W = DATA_W / STRB_W;
    localparam int OFF_W  = 4;

    logic              clk, rst;
    logic [ADDR_W-1:0] AWADDR, ARADDR;
    logic              AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic              ARVALID, ARREADY, RVALID, RREADY;
    logic [DATA_W-1:0] WDATA, RDATA;
    logic [STRB_W-1:0] WSTRB;
    logic [1:0]        BRESP, RRESP;

    axi4_lite_mem_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .S_AXI_AWADDR(AWADDR), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
        .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
        .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
        .S_AXI_ARADDR(ARADDR), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
        .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: one entry per in-range line that has been written.
    logic [DATA_W-1:0] ref_mem [int];

    function automatic logic [DATA_W-1:0] rnd_line();
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic int line_of(input logic [ADDR_W-1:0] a);
        return int'(a) / (DATA_W / 8);
    endfunction

    function automatic logic [1:0] exp_resp(input logic [ADDR_W-1:0] a);
        return (line_of(a) < DEPTH) ? 2'b00 : 2'b11;
    endfunction

    task automatic ref_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
        logic [DATA_W-1:0] m;
        logic [DATA_W-1:0] old;
        int ln;
        ln = line_of(a);
        if (ln >= DEPTH) return;
        m = '0;
        for (int l = 0; l < STRB_W; l++)
            if (s[l]) m[l*LANE_W +: LANE_W] = {LANE_W{1'b1}};
        old = ref_mem.exists(ln) ? ref_mem[ln] : '0;
        ref_mem[ln] = (old & ~m) | (d & m);
    endtask

    function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
        int ln;
        ln = line_of(a);
        if (ln >= DEPTH || !ref_mem.exists(ln)) return '0;
        return ref_mem[ln];
    endfunction

    task automatic axi_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s,
                             input int aw_dly, input int w_dly, input int b_dly,
                             output logic [1:0] resp, output int lat);
        bit aw_done, w_done;
        int cyc;
        aw_done = 0; w_done = 0; cyc = 0;
        lat = -1; resp = 2'bxx;
        while (!(aw_done && w_done) && cyc < 50) begin
            @(negedge clk);
            if (w_done && !aw_done) begin
                chk("w_ready_drop", WREADY, 1'b0);
                chk("aw_ready_hold", AWREADY, 1'b1);
            end
            if (aw_done && !w_done) begin
                chk("aw_ready_drop", AWREADY, 1'b0);
                chk("w_ready_hold", WREADY, 1'b1);
            end
            AWADDR  = a;
            WDATA   = d;
            WSTRB   = s;
            AWVALID = !aw_done && cyc >= aw_dly;
            WVALID  = !w_done  && cyc >= w_dly;
            if (AWVALID && AWREADY) aw_done = 1;
            if (WVALID && WREADY)   w_done  = 1;
            cyc++;
        end
        if (!(aw_done && w_done)) chk("aw_w_timeout", 1'b0, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            AWVALID = 0; WVALID = 0; BREADY = 0;
            if (BVALID) begin
                if (lat < 0) begin lat = k; resp = BRESP; end
                else chk("bresp_stable", BRESP, resp);
                if (k - lat >= b_dly) begin BREADY = 1; break; end
            end
        end
        if (lat < 0) chk("bvalid_timeout", 1'b0, 1'b1);
        @(negedge clk);
        BREADY = 0;
        chk("bvalid_clear", BVALID, 1'b0);
    endtask

    task automatic axi_read(input logic [ADDR_W-1:0] a, input int r_dly,
                            output logic [DATA_W-1:0] data, output logic [1:0] resp, output int lat);
        int c;
        lat = -1; resp = 2'bxx; data = 'x;
        @(negedge clk);
        ARADDR = a; ARVALID = 1; c = 0;
        while (!ARREADY && c < 20) begin @(negedge clk); c++; end
        if (!ARREADY) chk("arready_timeout", 1'b0, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            ARVALID = 0; RREADY = 0;
            if (RVALID) begin
                if (lat < 0) begin lat = k; resp = RRESP; data = RDATA; end
                else begin
                    chk("rresp_stable", RRESP, resp);
                    chk("rdata_stable", RDATA, data);
                end
                if (k - lat >= r_dly) begin RREADY = 1; break; end
            end
        end
        if (lat < 0) chk("rvalid_timeout", 1'b0, 1'b1);
        @(negedge clk);
        RREADY = 0;
        chk("rvalid_clear", RVALID, 1'b0);
    endtask

    task automatic wr_chk(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [STRB_W-1:0] s, input int aw_dly, input int w_dly, input int b_dly);
        logic [1:0] resp;
        int lat;
        axi_write(a, d, s, aw_dly, w_dly, b_dly, resp, lat);
        chk({tag, "_bresp"}, resp, exp_resp(a));
        chk({tag, "_blat"}, lat, 2);
        ref_write(a, d, s);
    endtask

    task automatic rd_chk(input string tag, input logic [ADDR_W-1:0] a, input int r_dly);
        logic [DATA_W-1:0] data;
        logic [1:0] resp;
        int lat;
        axi_read(a, r_dly, data, resp, lat);
        chk({tag, "_rresp"}, resp, exp_resp(a));
        chk({tag, "_rdata"}, data, ref_read(a));
        chk({tag, "_rlat"}, lat, 2);
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_awready"}, AWREADY, 1'b0);
        chk({tag, "_wready"},  WREADY,  1'b0);
        chk({tag, "_arready"}, ARREADY, 1'b0);
        chk({tag, "_bvalid"},  BVALID,  1'b0);
        chk({tag, "_rvalid"},  RVALID,  1'b0);
        chk({tag, "_bresp"},   BRESP,   2'b00);
        chk({tag, "_rresp"},   RRESP,   2'b00);
        chk({tag, "_rdata"},   RDATA,   {DATA_W{1'b0}});
    endtask

    task automatic chk_readies(input string tag);
        chk({tag, "_awready"}, AWREADY, 1'b1);
        chk({tag, "_wready"},  WREADY,  1'b1);
        chk({tag, "_arready"}, ARREADY, 1'b1);
    endtask

    logic [DATA_W-1:0] d_a5, d_5a, d_tmp, d_keep;
    logic [DATA_W-1:0] exp_part;

    initial begin
        rst = 0; AWADDR = '0; ARADDR = '0; WDATA = '0; WSTRB = '0;
        AWVALID = 0; WVALID = 0; BREADY = 0; ARVALID = 0; RREADY = 0;
        d_a5 = {(DATA_W/8){8'hA5}};
        d_5a = {(DATA_W/8){8'h5A}};

        repeat (3) @(negedge clk);
        chk_idle_reset("rst");
        rst = 1;
        @(negedge clk);
        chk_readies("post_rst");

        // In-range write with AW and W together, then readback.
        wr_chk("wr40", 12'h040, d_a5, 8'hFF, 0, 0, 0);
        rd_chk("rd40", 12'h040, 0);

        // W three cycles ahead of AW.
        wr_chk("w_first", 12'h080, rnd_line(), 8'hFF, 3, 0, 1);
        rd_chk("rd80", 12'h080, 2);
        // AW ahead of W, with low address offset bits set (ignored).
        wr_chk("aw_first", 12'h08F, rnd_line(), 8'hFF, 0, 2, 0);
        rd_chk("rd80b", 12'h083, 0);

        // Partial strobe on an all-ones line.
        wr_chk("ones100", 12'h100, {DATA_W{1'b1}}, 8'hFF, 0, 0, 0);
        wr_chk("part100", 12'h100, {DATA_W{1'b0}}, 8'h01, 0, 0, 0);
        exp_part = {{(DATA_W-LANE_W){1'b1}}, {LANE_W{1'b0}}};
        chk("part_model", ref_read(12'h100), exp_part);
        rd_chk("rd100", 12'h100, 0);
        wr_chk("strb0", 12'h100, rnd_line(), 8'h00, 1, 0, 0);
        rd_chk("rd100z", 12'h100, 0);

        // Out of range; 0xC00 would alias 0x400 if the index were truncated.
        wr_chk("wr400", 12'h400, rnd_line(), 8'hFF, 0, 0, 0);
        wr_chk("wrC00", 12'hC00, rnd_line(), 8'hFF, 0, 0, 0);
        rd_chk("rdC00", 12'hC00, 1);
        rd_chk("rd400", 12'h400, 0);

        // Read lands in R_ACC on the commit cycle of a write to the same line.
        @(negedge clk);
        AWADDR = 12'h040; WDATA = d_5a; WSTRB = 8'hFF; AWVALID = 1; WVALID = 1;
        ARADDR = 12'h040; ARVALID = 1;
        chk_readies("coll_pre");
        @(negedge clk);
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        chk("coll_k1_rvalid", RVALID, 1'b0);
        @(negedge clk);
        chk("coll_k2_bvalid", BVALID, 1'b1);
        chk("coll_k2_stall", RVALID, 1'b0);
        BREADY = 1;
        ref_write(12'h040, d_5a, 8'hFF);
        @(negedge clk);
        BREADY = 0;
        chk("coll_k3_rvalid", RVALID, 1'b1);
        chk("coll_k3_rdata", RDATA, d_5a);
        chk("coll_k3_rresp", RRESP, 2'b00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("coll_hold_rvalid", RVALID, 1'b1);
            chk("coll_hold_rdata", RDATA, d_5a);
        end
        RREADY = 1;
        @(negedge clk);
        RREADY = 0;
        chk("coll_done", RVALID, 1'b0);

        // Reset while both responses are pending.
        d_tmp = rnd_line();
        @(negedge clk);
        AWADDR = 12'h080; WDATA = d_tmp; WSTRB = 8'hFF; AWVALID = 1; WVALID = 1;
        ARADDR = 12'h040; ARVALID = 1;
        @(negedge clk);
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        for (int i = 0; i < 10 && !(BVALID && RVALID); i++) @(negedge clk);
        chk("pre_rst_bvalid", BVALID, 1'b1);
        chk("pre_rst_rvalid", RVALID, 1'b1);
        ref_write(12'h080, d_tmp, 8'hFF);
        rst = 0;
        @(negedge clk);
        chk_idle_reset("mid_rst");
        rst = 1;
        @(negedge clk);
        chk_readies("mid_rst_rel");
        wr_chk("after_rst", 12'h080, rnd_line(), 8'h3C, 0, 1, 0);
        rd_chk("rd_after_rst", 12'h080, 0);

        // Reset asserted on the commit cycle suppresses the write.
        wr_chk("keep0C0", 12'h0C0, rnd_line(), 8'hFF, 0, 0, 0);
        d_keep = ~ref_read(12'h0C0);
        @(negedge clk);
        AWADDR = 12'h0C0; WDATA = d_keep; WSTRB = 8'hFF; AWVALID = 1; WVALID = 1;
        @(negedge clk);
        AWVALID = 0; WVALID = 0;
        rst = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rd_chk("rd_suppressed", 12'h0C0, 0);

        // Randomized traffic over a small set of initialized lines plus out-of-range ones.
        for (int ln = 0; ln < 16; ln++)
            wr_chk("init", ADDR_W'(ln << OFF_W), rnd_line(), 8'hFF, 0, 0, 0);
        for (int it = 0; it < 80; it++) begin
            int ln;
            logic [ADDR_W-1:0] a;
            logic [STRB_W-1:0] s;
            ln = ($urandom_range(0, 7) == 0) ? int'($urandom_range(DEPTH, 255)) : int'($urandom_range(0, 15));
            a  = ADDR_W'((ln << OFF_W) | int'($urandom_range(0, 15)));
            if ($urandom_range(0, 1) == 1) begin
                s = ($urandom_range(0, 5) == 0) ? 8'h00 : STRB_W'($urandom);
                wr_chk("rnd_wr", a, rnd_line(), s, int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            end else begin
                rd_chk("rnd_rd", a, int'($urandom_range(0, 3)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
